sc_ball_shiftregister: RTL and testbench
========================================

SC_BALL_SHIFTREGISTER -- requirements
Module: SC_BALL_SHIFTREGISTER

Interface
REQ-001 SHALL provide parameters, one per line:
- BALLSHIFTREGISTER_DATAWIDTH, 8, position bus width.
- BALLSHIFTREGISTER_LOADVALUE, 8'b00010000, one-hot position applied on load.
- BALLSHIFTREGISTER_TICKDIV, 16, clock cycles per position step (>=2).
REQ-002 SHALL provide ports, one per line (name, direction, width, meaning):
- SC_BALL_SHIFTREGISTER_CLOCK_50, in, 1, single clock; all state updates on rising edge.
- SC_BALL_SHIFTREGISTER_RESET_InLow, in, 1, asynchronous active-low reset.
- SC_BALL_SHIFTREGISTER_load_InHigh, in, 1, load LOADVALUE and start moving.
- SC_BALL_SHIFTREGISTER_dirleft_InHigh, in, 1, initial direction sampled on load (1 = left, toward MSB).
- SC_BALL_SHIFTREGISTER_pause_InHigh, in, 1, freeze position and prescaler.
- SC_BALL_SHIFTREGISTER_data_OutBUS, out, DATAWIDTH, one-hot ball position driving the side comparators.
- SC_BALL_SHIFTREGISTER_dirleft_OutHigh, out, 1, current direction.
- SC_BALL_SHIFTREGISTER_bounce_OutHigh, out, 1, one-cycle pulse on a wall reversal.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-004 SHALL implement FSM states IDLE, MOVE_LEFT, MOVE_RIGHT, PAUSED.
REQ-005 In IDLE, data_OutBUS SHALL be all zeros and the prescaler SHALL hold at 0.
REQ-006 load_InHigh high in any state SHALL, on the next edge: set data to LOADVALUE, clear the prescaler, and enter MOVE_LEFT if dirleft_InHigh=1, else MOVE_RIGHT.
REQ-007 Load SHALL take priority over pause, tick and bounce in the same cycle.
REQ-008 The prescaler SHALL count 0..TICKDIV-1 in MOVE states and wrap to 0; a step SHALL occur on the edge where the count equals TICKDIV-1.
REQ-009 Step in MOVE_LEFT with MSB clear SHALL shift the data left by 1, zero-filled.
REQ-010 Step in MOVE_LEFT with MSB set SHALL instead shift right by 1, enter MOVE_RIGHT, and assert bounce_OutHigh for exactly that one cycle.
REQ-011 MOVE_RIGHT SHALL mirror REQ-009/010 with LSB, right shift and MOVE_LEFT.
REQ-012 data_OutBUS SHALL stay one-hot in every MOVE/PAUSED state; the position SHALL never wrap around the bus.
REQ-013 pause_InHigh high in a MOVE state SHALL enter PAUSED next edge, retaining position, direction and prescaler count.
REQ-014 pause_InHigh low in PAUSED SHALL return to the retained MOVE state; counting SHALL resume from the retained value.
REQ-015 A pause asserted on a step edge SHALL suppress that step.
REQ-016 dirleft_OutHigh SHALL be 1 in MOVE_LEFT or in PAUSED-from-left, else 0.
REQ-017 All outputs SHALL be registered, with zero combinational input-to-output paths.

Reset
REQ-018 Reset low SHALL immediately force IDLE, data 0, prescaler 0, dirleft_OutHigh 0, bounce_OutHigh 0, independent of clock.
REQ-019 Reset mid-move or mid-pause SHALL discard position; release SHALL stay in IDLE until load.

Structure
REQ-020 A shared package SHALL hold the FSM state enumeration, DATAWIDTH default and LOADVALUE default.
REQ-021 The prescaler SHALL be a sub-module SC_BALL_TICKPRESCALER (enable, clear, step pulse output).

Verification (DATAWIDTH=8, TICKDIV=4, LOADVALUE=8'b00010000)
REQ-022 Reset low mid-move -> data 8'h00, bounce 0, dirleft 0 with no clock edge; after release, outputs remain 0 until load.
REQ-023 Load with dirleft=1 -> 8'h10, then 8'h20, 8'h40, 8'h80 at 4-cycle spacing; next step 8'h40, bounce pulses 1 cycle, dirleft 0.
REQ-024 Load with dirleft=0 -> 8'h08, 8'h04, 8'h02, 8'h01; next step 8'h02 with bounce and dirleft 1; 8'h08 reached, enabling the bottom-side comparator.
REQ-025 Pause 2 cycles after a step, held 10 cycles -> position frozen; first step comes exactly 2 cycles after release.
REQ-026 Load asserted on a step edge at 8'h80 -> data 8'h10, no bounce pulse, prescaler 0.
REQ-027 Assertion over all runs: data_OutBUS is one-hot or zero; bounce_OutHigh is never high for 2 consecutive cycles.

Source files
------------

// File: rtl/sc_ball_shiftregister_pkg.sv
// ============================================================================
// sc_ball_shiftregister_pkg: shared FSM encoding and bus defaults. Rev 1.0
// ============================================================================
`default_nettype none

package sc_ball_shiftregister_pkg;

    localparam int                           DATAWIDTH_DEFAULT = 8;
    localparam logic [DATAWIDTH_DEFAULT-1:0] LOADVALUE_DEFAULT = 8'b0001_0000;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        MOVE_LEFT  = 2'd1,
        MOVE_RIGHT = 2'd2,
        PAUSED     = 2'd3
    } ball_state_t;

endpackage : sc_ball_shiftregister_pkg

`default_nettype wire

// File: rtl/sc_ball_tickprescaler.sv
// ============================================================================
// sc_ball_tickprescaler: modulo-TICKDIV counter issuing the position step. Rev 1.0
// ============================================================================
`default_nettype none

module sc_ball_tickprescaler #(
    parameter int TICKDIV = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic step
);

    localparam int             CW   = $clog2(TICKDIV);
    localparam logic [CW-1:0]  LAST = CW'(TICKDIV - 1);

    logic [CW-1:0] count;

    // Step is qualified by enable so a frozen prescaler never fires.
    assign step = enable && (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= step ? '0 : count + CW'(1);
        end
    end

endmodule : sc_ball_tickprescaler

`default_nettype wire

// File: rtl/sc_ball_shiftregister.sv
// ============================================================================
// sc_ball_shiftregister: one-hot ball position bouncing between bus walls. Rev 1.0
// ============================================================================
`default_nettype none

module sc_ball_shiftregister
    import sc_ball_shiftregister_pkg::*;
#(
    parameter int                                      BALLSHIFTREGISTER_DATAWIDTH = DATAWIDTH_DEFAULT,
    parameter logic [BALLSHIFTREGISTER_DATAWIDTH-1:0]  BALLSHIFTREGISTER_LOADVALUE = LOADVALUE_DEFAULT,
    parameter int                                      BALLSHIFTREGISTER_TICKDIV   = 16
) (
    input  logic                                   SC_BALL_SHIFTREGISTER_CLOCK_50,
    input  logic                                   SC_BALL_SHIFTREGISTER_RESET_InLow,
    input  logic                                   SC_BALL_SHIFTREGISTER_load_InHigh,
    input  logic                                   SC_BALL_SHIFTREGISTER_dirleft_InHigh,
    input  logic                                   SC_BALL_SHIFTREGISTER_pause_InHigh,
    output logic [BALLSHIFTREGISTER_DATAWIDTH-1:0] SC_BALL_SHIFTREGISTER_data_OutBUS,
    output logic                                   SC_BALL_SHIFTREGISTER_dirleft_OutHigh,
    output logic                                   SC_BALL_SHIFTREGISTER_bounce_OutHigh
);

    localparam int DW = BALLSHIFTREGISTER_DATAWIDTH;

    logic clk;
    logic rst_n;
    logic load;
    logic pause;

    assign clk   = SC_BALL_SHIFTREGISTER_CLOCK_50;
    assign rst_n = SC_BALL_SHIFTREGISTER_RESET_InLow;
    assign load  = SC_BALL_SHIFTREGISTER_load_InHigh;
    assign pause = SC_BALL_SHIFTREGISTER_pause_InHigh;

    ball_state_t   state;
    ball_state_t   state_nxt;
    logic [DW-1:0] data;
    logic [DW-1:0] data_nxt;
    logic          dir_left;
    logic          dir_nxt;
    logic          bounce;
    logic          bounce_nxt;

    logic          tick_en;
    logic          tick_clr;
    logic          tick_step;
    logic          at_wall;

    // The prescaler only advances while the ball is live and not held; load
    // restarts the step interval from zero.
    assign tick_en  = (state != IDLE) && !pause && !load;
    assign tick_clr = load || (state == IDLE);

    sc_ball_tickprescaler #(
        .TICKDIV (BALLSHIFTREGISTER_TICKDIV)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (tick_en),
        .clear  (tick_clr),
        .step   (tick_step)
    );

    assign at_wall = dir_left ? data[DW-1] : data[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            data     <= '0;
            dir_left <= 1'b0;
            bounce   <= 1'b0;
        end else begin
            state    <= state_nxt;
            data     <= data_nxt;
            dir_left <= dir_nxt;
            bounce   <= bounce_nxt;
        end
    end

    // dir_left holds the retained direction while PAUSED, so resuming and
    // stepping both follow it rather than the encoded state.
    always_comb begin
        state_nxt  = state;
        data_nxt   = data;
        dir_nxt    = dir_left;
        bounce_nxt = 1'b0;

        if (load) begin
            data_nxt  = BALLSHIFTREGISTER_LOADVALUE;
            dir_nxt   = SC_BALL_SHIFTREGISTER_dirleft_InHigh;
            state_nxt = SC_BALL_SHIFTREGISTER_dirleft_InHigh ? MOVE_LEFT : MOVE_RIGHT;
        end else if (state == IDLE) begin
            data_nxt = '0;
            dir_nxt  = 1'b0;
        end else if (pause) begin
            state_nxt = PAUSED;
        end else begin
            state_nxt = dir_left ? MOVE_LEFT : MOVE_RIGHT;
            if (tick_step) begin
                if (at_wall) begin
                    data_nxt   = dir_left ? (data >> 1) : (data << 1);
                    dir_nxt    = !dir_left;
                    state_nxt  = dir_left ? MOVE_RIGHT : MOVE_LEFT;
                    bounce_nxt = 1'b1;
                end else begin
                    data_nxt = dir_left ? (data << 1) : (data >> 1);
                end
            end
        end
    end

    assign SC_BALL_SHIFTREGISTER_data_OutBUS     = data;
    assign SC_BALL_SHIFTREGISTER_dirleft_OutHigh = dir_left;
    assign SC_BALL_SHIFTREGISTER_bounce_OutHigh  = bounce;

endmodule : sc_ball_shiftregister

`default_nettype wire

// File: tb/tb_sc_ball_shiftregister.sv
// ============================================================================
// tb_sc_ball_shiftregister: directed and random checks against a position model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_sc_ball_shiftregister;

    localparam int TICKDIV  = 4;
    localparam int LOAD_POS = 4;

    logic       clk;
    logic       rst_n;
    logic       load;
    logic       dirleft;
    logic       pause;
    logic [7:0] data_bus;
    logic       dir_out;
    logic       bounce_out;

    int n_tests;
    int n_fail;

    // Ball model: integer position index, +1/-1 direction, elapsed counting edges.
    bit  m_active;
    int  m_pos;
    int  m_dir;
    int  m_cnt;
    bit  m_bounce;
    bit  prev_bounce;
    bit  pz_state;

    sc_ball_shiftregister #(
        .BALLSHIFTREGISTER_DATAWIDTH (8),
        .BALLSHIFTREGISTER_LOADVALUE (8'b0001_0000),
        .BALLSHIFTREGISTER_TICKDIV   (TICKDIV)
    ) dut (
        .SC_BALL_SHIFTREGISTER_CLOCK_50       (clk),
        .SC_BALL_SHIFTREGISTER_RESET_InLow    (rst_n),
        .SC_BALL_SHIFTREGISTER_load_InHigh    (load),
        .SC_BALL_SHIFTREGISTER_dirleft_InHigh (dirleft),
        .SC_BALL_SHIFTREGISTER_pause_InHigh   (pause),
        .SC_BALL_SHIFTREGISTER_data_OutBUS    (data_bus),
        .SC_BALL_SHIFTREGISTER_dirleft_OutHigh(dir_out),
        .SC_BALL_SHIFTREGISTER_bounce_OutHigh (bounce_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_data();
        logic [7:0] one;
        one = 8'h01;
        return m_active ? (one << m_pos) : 8'h00;
    endfunction

    function automatic logic exp_dir();
        return m_active && (m_dir > 0);
    endfunction

    task automatic model_reset();
        m_active    = 1'b0;
        m_pos       = 0;
        m_dir       = -1;
        m_cnt       = 0;
        m_bounce    = 1'b0;
        prev_bounce = 1'b0;
    endtask

    // One clock edge of the ball: a step every TICKDIV unpaused edges,
    // reversing instead of leaving the bus.
    task automatic model_step(input bit ld, input bit dl, input bit pz);
        m_bounce = 1'b0;
        if (ld) begin
            m_active = 1'b1;
            m_pos    = LOAD_POS;
            m_dir    = dl ? 1 : -1;
            m_cnt    = 0;
        end else if (m_active && !pz) begin
            m_cnt++;
            if (m_cnt == TICKDIV) begin
                m_cnt = 0;
                if (m_pos + m_dir < 0 || m_pos + m_dir > 7) begin
                    m_dir    = -m_dir;
                    m_bounce = 1'b1;
                end
                m_pos += m_dir;
            end
        end
    endtask

    task automatic cycle(input bit ld, input bit dl, input bit pz);
        load    = ld;
        dirleft = dl;
        pause   = pz;
        @(posedge clk);
        model_step(ld, dl, pz);
        @(negedge clk);
        check_eq("data", {24'h0, data_bus}, {24'h0, exp_data()});
        check_eq("dirleft", {31'h0, dir_out}, {31'h0, exp_dir()});
        check_eq("bounce", {31'h0, bounce_out}, {31'h0, m_bounce});
        check_eq("onehot0", {31'h0, $onehot0(data_bus)}, 32'd1);
        check_eq("bounce_run", {31'h0, prev_bounce & bounce_out}, 32'd0);
        prev_bounce = bounce_out;
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous assertion, checked before any clock edge can occur.
    task automatic do_reset();
        load    = 1'b0;
        pause   = 1'b0;
        dirleft = 1'b0;
        rst_n   = 1'b0;
        #1;
        check_eq("rst_data", {24'h0, data_bus}, 32'h0);
        check_eq("rst_bounce", {31'h0, bounce_out}, 32'h0);
        check_eq("rst_dir", {31'h0, dir_out}, 32'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        pz_state = 1'b0;
        load     = 1'b0;
        dirleft  = 1'b0;
        pause    = 1'b0;
        rst_n    = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_eq("init_data", {24'h0, data_bus}, 32'h0);
        rst_n = 1'b1;
        run_idle(3);

        // Left launch, climb to the MSB wall and bounce back.
        cycle(1'b1, 1'b1, 1'b0);
        check_eq("l_load", {24'h0, data_bus}, 32'h10);
        check_eq("l_dir", {31'h0, dir_out}, 32'h1);
        run_idle(4);  check_eq("l_20", {24'h0, data_bus}, 32'h20);
        run_idle(4);  check_eq("l_40", {24'h0, data_bus}, 32'h40);
        run_idle(4);  check_eq("l_80", {24'h0, data_bus}, 32'h80);
        run_idle(4);
        check_eq("l_bounce_pos", {24'h0, data_bus}, 32'h40);
        check_eq("l_bounce", {31'h0, bounce_out}, 32'h1);
        check_eq("l_bounce_dir", {31'h0, dir_out}, 32'h0);
        run_idle(1);
        check_eq("l_bounce_end", {31'h0, bounce_out}, 32'h0);

        // Right launch, down to the LSB wall and back up to 8'h08.
        cycle(1'b1, 1'b0, 1'b0);
        check_eq("r_load", {24'h0, data_bus}, 32'h10);
        run_idle(4);  check_eq("r_08", {24'h0, data_bus}, 32'h08);
        run_idle(4);  check_eq("r_04", {24'h0, data_bus}, 32'h04);
        run_idle(4);  check_eq("r_02", {24'h0, data_bus}, 32'h02);
        run_idle(4);  check_eq("r_01", {24'h0, data_bus}, 32'h01);
        run_idle(4);
        check_eq("r_bounce_pos", {24'h0, data_bus}, 32'h02);
        check_eq("r_bounce", {31'h0, bounce_out}, 32'h1);
        check_eq("r_bounce_dir", {31'h0, dir_out}, 32'h1);
        run_idle(8);  check_eq("r_back_08", {24'h0, data_bus}, 32'h08);

        // Pause two edges after a step, held ten edges.
        cycle(1'b1, 1'b1, 1'b0);
        run_idle(4);
        cycle(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, 1'b1);
            check_eq("p_frozen", {24'h0, data_bus}, 32'h20);
        end
        cycle(1'b0, 1'b0, 1'b0);
        check_eq("p_rel0", {24'h0, data_bus}, 32'h20);
        cycle(1'b0, 1'b0, 1'b0);
        check_eq("p_rel1", {24'h0, data_bus}, 32'h20);
        cycle(1'b0, 1'b0, 1'b0);
        check_eq("p_rel2_step", {24'h0, data_bus}, 32'h40);

        // Load on the bouncing step edge wins and restarts the prescaler.
        cycle(1'b1, 1'b1, 1'b0);
        run_idle(12);
        check_eq("lb_80", {24'h0, data_bus}, 32'h80);
        run_idle(3);
        cycle(1'b1, 1'b1, 1'b0);
        check_eq("lb_data", {24'h0, data_bus}, 32'h10);
        check_eq("lb_nobounce", {31'h0, bounce_out}, 32'h0);
        run_idle(3);
        check_eq("lb_hold", {24'h0, data_bus}, 32'h10);
        run_idle(1);
        check_eq("lb_step", {24'h0, data_bus}, 32'h20);

        // Reset mid-move discards the ball until the next load.
        cycle(1'b1, 1'b0, 1'b0);
        run_idle(6);
        do_reset();
        run_idle(6);
        check_eq("post_rst_idle", {24'h0, data_bus}, 32'h0);

        // Randomized traffic with sporadic loads, pause bursts and resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 7) == 0) pz_state = ~pz_state;
                cycle(($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)), pz_state);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_sc_ball_shiftregister

`default_nettype wire
